// File: rtl/func_bist_ctrl.sv
// BIST sequencer for f = x1'x2'x3' + x1'x3'x4 + x1x2x4' + x2x3: sweeps all 16 vectors into
// the NAND and NOR netlists, samples after a settle delay and scores both against GOLDEN.
module func_bist_ctrl #(
  parameter logic [15:0] GOLDEN        = 16'hD0E3,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic [3:0] vec,
  input  logic       nand_in,
  input  logic       nor_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_nand_cnt,
  output logic [4:0] err_nor_cnt,
  output logic       fail_valid,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     state, next_state;
  logic [7:0] settle_cnt;
  logic       accept;
  logic       golden_bit;
  logic       nand_mis;
  logic       nor_mis;

  assign accept     = (state == IDLE) && start && !abort;
  assign golden_bit = GOLDEN[vec];
  assign nand_mis   = (nand_in != golden_bit);
  assign nor_mis    = (nor_in != golden_bit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start && !abort) next_state = DRIVE;
      DRIVE: begin
        if (abort)                          next_state = IDLE;
        else if (settle_cnt == SETTLE_LAST) next_state = SAMPLE;
      end
      SAMPLE: begin
        if (abort)              next_state = IDLE;
        else if (vec == 4'hF)   next_state = DONE;
        else                    next_state = DRIVE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered outputs; an abort suppresses the scoring of a SAMPLE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec          <= 4'd0;
      settle_cnt   <= 8'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_nand_cnt <= 5'd0;
      err_nor_cnt  <= 5'd0;
      fail_valid   <= 1'b0;
      fail_vec     <= 4'd0;
    end else begin
      busy <= (next_state == DRIVE) || (next_state == SAMPLE);
      done <= (state == DONE);
      if (accept) begin
        vec          <= 4'd0;
        settle_cnt   <= 8'd0;
        pass         <= 1'b0;
        err_nand_cnt <= 5'd0;
        err_nor_cnt  <= 5'd0;
        fail_valid   <= 1'b0;
        fail_vec     <= 4'd0;
      end else begin
        case (state)
          DRIVE: begin
            if (!abort) settle_cnt <= settle_cnt + 8'd1;
          end
          SAMPLE: begin
            if (!abort) begin
              if (nand_mis) err_nand_cnt <= err_nand_cnt + 5'd1;
              if (nor_mis)  err_nor_cnt  <= err_nor_cnt + 5'd1;
              if (!fail_valid && (nand_mis || nor_mis)) begin
                fail_vec   <= vec;
                fail_valid <= 1'b1;
              end
              if (vec != 4'hF) begin
                vec        <= vec + 4'd1;
                settle_cnt <= 8'd0;
              end
            end
          end
          DONE: begin
            pass <= (err_nand_cnt == 5'd0) && (err_nor_cnt == 5'd0);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_func_bist_ctrl.sv
// Testbench for func_bist_ctrl: netlists are modelled as truth tables, expectations
// come from mismatch masks against the golden function.
module tb_func_bist_ctrl;

  localparam logic [15:0] GOLDEN = 16'hD0E3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0, abort = 1'b0;
  logic [3:0]  vec, fail_vec;
  logic        nand_in, nor_in, busy, done, pass, fail_valid;
  logic [4:0]  err_nand_cnt, err_nor_cnt;
  logic [15:0] nand_tt = GOLDEN, nor_tt = GOLDEN;

  assign nand_in = nand_tt[vec];
  assign nor_in  = nor_tt[vec];

  func_bist_ctrl #(.GOLDEN(GOLDEN), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .vec(vec),
    .nand_in(nand_in), .nor_in(nor_in), .busy(busy), .done(done), .pass(pass),
    .err_nand_cnt(err_nand_cnt), .err_nor_cnt(err_nor_cnt),
    .fail_valid(fail_valid), .fail_vec(fail_vec)
  );

  // Second instance with a one-cycle settle, driven by netlists that lag vec by two cycles.
  logic        start1 = 1'b0, abort1 = 1'b0;
  logic [3:0]  vec1, fail_vec1, vec_d1, vec_d2;
  logic        nand_in1, nor_in1, busy1, done1, pass1, fail_valid1;
  logic [4:0]  err_nand_cnt1, err_nor_cnt1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_d1 <= 4'd0;
      vec_d2 <= 4'd0;
    end else begin
      vec_d1 <= vec1;
      vec_d2 <= vec_d1;
    end
  end

  assign nand_in1 = GOLDEN[vec_d2];
  assign nor_in1  = GOLDEN[vec_d2];

  func_bist_ctrl #(.GOLDEN(GOLDEN), .SETTLE_CYCLES(1)) dut_s1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .vec(vec1),
    .nand_in(nand_in1), .nor_in(nor_in1), .busy(busy1), .done(done1), .pass(pass1),
    .err_nand_cnt(err_nand_cnt1), .err_nor_cnt(err_nor_cnt1),
    .fail_valid(fail_valid1), .fail_vec(fail_vec1)
  );

  int   errors = 0;
  int   checks = 0;
  int   trace_vec [0:255];
  logic trace_busy [0:255];

  function automatic logic [3:0] first_set(input logic [15:0] m);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 15; i >= 0; i--) if (m[i]) r = 4'(i);
    return r;
  endfunction

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge right after the accepting edge; lat counts edges since acceptance.
  task automatic wait_done(input int max_cycles, output int lat, output bit hit);
    hit = 1'b0;
    lat = 0;
    while (lat <= max_cycles) begin
      trace_vec[lat]  = int'(vec);
      trace_busy[lat] = busy;
      if (done === 1'b1) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({vec, busy, done, pass, err_nand_cnt, err_nor_cnt, fail_valid, fail_vec} !== 23'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected 0",
               {vec, busy, done, pass, err_nand_cnt, err_nor_cnt, fail_valid, fail_vec});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, pass, vec} !== 7'd0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got %h expected 0", {busy, done, pass, vec});
    end
  endtask

  task automatic test_good_sweep();
    int lat, bad;
    bit hit;
    nand_tt = GOLDEN;
    nor_tt  = GOLDEN;
    start_pulse();
    wait_done(200, lat, hit);
    checks++;
    if (!hit || lat != 49) begin
      errors++;
      $display("[TB] FAIL good_latency: got %0d (hit=%0d) expected 49", lat, hit);
    end
    bad = 0;
    if (hit && lat == 49)
      for (int k = 0; k <= 48; k++) begin
        if (trace_vec[k] != ((k / 3 > 15) ? 15 : k / 3)) bad++;
        if (trace_busy[k] !== (k < 48)) bad++;
      end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL vec_busy_trace: got %0d bad cycles expected 0", bad);
    end
    checks++;
    if ({pass, err_nand_cnt, err_nor_cnt, fail_valid, vec} !== {1'b1, 5'd0, 5'd0, 1'b0, 4'hF}) begin
      errors++;
      $display("[TB] FAIL good_result: got %h expected %h",
               {pass, err_nand_cnt, err_nor_cnt, fail_valid, vec}, {1'b1, 5'd0, 5'd0, 1'b0, 4'hF});
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || pass !== 1'b1) begin
      errors++;
      $display("[TB] FAIL done_one_cycle: got done=%0d pass=%0d expected done=0 pass=1", done, pass);
    end
  endtask

  task automatic test_fault_models();
    logic [15:0] tn [8];
    logic [15:0] to [8];
    logic [15:0] mn, mo;
    int lat, en, eo;
    bit hit;
    tn[0] = GOLDEN;                                 to[0] = 16'h0000;
    tn[1] = GOLDEN ^ 16'h4800;                      to[1] = GOLDEN;
    for (int c = 2; c < 8; c++) begin
      tn[c] = GOLDEN ^ 16'($urandom & $urandom & $urandom);
      to[c] = GOLDEN ^ 16'($urandom & $urandom);
    end
    for (int c = 0; c < 8; c++) begin
      nand_tt = tn[c];
      nor_tt  = to[c];
      mn = tn[c] ^ GOLDEN;
      mo = to[c] ^ GOLDEN;
      en = $countones(mn);
      eo = $countones(mo);
      start_pulse();
      wait_done(200, lat, hit);
      checks++;
      if (!hit || lat != 49) begin
        errors++;
        $display("[TB] FAIL fault_latency case %0d: got %0d expected 49", c, lat);
      end
      checks++;
      if (err_nand_cnt !== 5'(en) || err_nor_cnt !== 5'(eo)) begin
        errors++;
        $display("[TB] FAIL fault_counts case %0d: got nand=%0d nor=%0d expected nand=%0d nor=%0d",
                 c, err_nand_cnt, err_nor_cnt, en, eo);
      end
      checks++;
      if (fail_valid !== ((mn | mo) != 0) || fail_vec !== first_set(mn | mo)) begin
        errors++;
        $display("[TB] FAIL fault_first case %0d: got valid=%0d vec=%h expected valid=%0d vec=%h",
                 c, fail_valid, fail_vec, ((mn | mo) != 0), first_set(mn | mo));
      end
      @(negedge clk);
      checks++;
      if (pass !== (en == 0 && eo == 0)) begin
        errors++;
        $display("[TB] FAIL fault_pass case %0d: got %0d expected %0d", c, pass, (en == 0 && eo == 0));
      end
    end
  endtask

  task automatic test_abort();
    logic [15:0] mn, mo;
    int lat, n;
    bit hit, saw_done, saw_pass;
    mn = 16'($urandom) | 16'h0004;
    mo = 16'($urandom);
    nand_tt = GOLDEN ^ mn;
    nor_tt  = GOLDEN ^ mo;
    start_pulse();
    for (n = 0; n < 100 && vec !== 4'd5; n++) @(negedge clk);
    checks++;
    if (vec !== 4'd5 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_reach_vec5: got vec=%h busy=%0d expected vec=5 busy=1", vec, busy);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || vec !== 4'd5) begin
      errors++;
      $display("[TB] FAIL abort_to_idle: got busy=%0d vec=%h expected busy=0 vec=5", busy, vec);
    end
    checks++;
    if (err_nand_cnt !== 5'($countones(mn & 16'h001F)) || err_nor_cnt !== 5'($countones(mo & 16'h001F))
        || fail_vec !== first_set((mn | mo) & 16'h001F)) begin
      errors++;
      $display("[TB] FAIL abort_partial: got nand=%0d nor=%0d fv=%h expected nand=%0d nor=%0d fv=%h",
               err_nand_cnt, err_nor_cnt, fail_vec, $countones(mn & 16'h001F),
               $countones(mo & 16'h001F), first_set((mn | mo) & 16'h001F));
    end
    saw_done = 1'b0;
    saw_pass = 1'b0;
    repeat (60) begin
      @(negedge clk);
      saw_done |= (done !== 1'b0);
      saw_pass |= (pass !== 1'b0);
    end
    checks++;
    if (saw_done || saw_pass) begin
      errors++;
      $display("[TB] FAIL abort_no_done: got done=%0d pass=%0d expected 0 0", saw_done, saw_pass);
    end
    start_pulse();
    checks++;
    if ({busy, vec, err_nand_cnt, err_nor_cnt, fail_valid} !== {1'b1, 4'd0, 5'd0, 5'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL restart_cleared: got %h expected %h",
               {busy, vec, err_nand_cnt, err_nor_cnt, fail_valid}, {1'b1, 4'd0, 5'd0, 5'd0, 1'b0});
    end
    wait_done(200, lat, hit);
    checks++;
    if (!hit || err_nand_cnt !== 5'($countones(mn)) || err_nor_cnt !== 5'($countones(mo))) begin
      errors++;
      $display("[TB] FAIL restart_counts: got nand=%0d nor=%0d expected nand=%0d nor=%0d",
               err_nand_cnt, err_nor_cnt, $countones(mn), $countones(mo));
    end
    @(negedge clk);
  endtask

  task automatic test_start_ignored_and_reset();
    int lat, n;
    bit hit, saw_done, saw_busy;
    nand_tt = GOLDEN;
    nor_tt  = GOLDEN;
    start_pulse();
    for (n = 0; n < 100 && vec !== 4'd7; n++) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n++;
    wait_done(200, lat, hit);
    checks++;
    if (!hit || n + lat != 49) begin
      errors++;
      $display("[TB] FAIL start_ignored_latency: got %0d expected 49", n + lat);
    end
    checks++;
    if ({err_nand_cnt, err_nor_cnt, fail_valid, vec} !== {5'd0, 5'd0, 1'b0, 4'hF}) begin
      errors++;
      $display("[TB] FAIL start_ignored_result: got %h expected %h",
               {err_nand_cnt, err_nor_cnt, fail_valid, vec}, {5'd0, 5'd0, 1'b0, 4'hF});
    end
    @(negedge clk);
    nor_tt = 16'h0000;
    start_pulse();
    for (n = 0; n < 100 && vec !== 4'd9; n++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({vec, busy, done, pass, err_nand_cnt, err_nor_cnt, fail_valid, fail_vec} !== 23'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: got %h expected 0",
               {vec, busy, done, pass, err_nand_cnt, err_nor_cnt, fail_valid, fail_vec});
    end
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    saw_busy = 1'b0;
    repeat (60) begin
      @(negedge clk);
      saw_done |= (done !== 1'b0);
      saw_busy |= (busy !== 1'b0);
    end
    checks++;
    if (saw_done || saw_busy) begin
      errors++;
      $display("[TB] FAIL reset_no_done: got done=%0d busy=%0d expected 0 0", saw_done, saw_busy);
    end
    nor_tt = GOLDEN;
  endtask

  task automatic test_idle_done_boundary();
    int n;
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || vec !== 4'd0) begin
      errors++;
      $display("[TB] FAIL start_with_abort: got busy=%0d vec=%h expected busy=0 vec=0", busy, vec);
    end
    start_pulse();
    for (n = 0; n < 100 && busy !== 1'b0; n++) @(negedge clk);
    checks++;
    if (n != 48) begin
      errors++;
      $display("[TB] FAIL busy_length: got %0d expected 48", n);
    end
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_in_done: got done=%0d pass=%0d busy=%0d expected 1 1 0", done, pass, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || vec !== 4'hF) begin
      errors++;
      $display("[TB] FAIL start_in_done_ignored: got busy=%0d vec=%h expected busy=0 vec=f", busy, vec);
    end
  endtask

  task automatic test_settle1();
    int lat, exp_cnt;
    logic [15:0] mask;
    mask = 16'd0;
    for (int v = 0; v < 16; v++)
      mask[v] = (GOLDEN[v] != GOLDEN[(v == 0) ? 0 : v - 1]);
    exp_cnt = $countones(mask);
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    lat = 0;
    while (lat < 100 && done1 !== 1'b1) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 33) begin
      errors++;
      $display("[TB] FAIL settle1_latency: got %0d expected 33", lat);
    end
    checks++;
    if (err_nand_cnt1 !== 5'(exp_cnt) || err_nor_cnt1 !== 5'(exp_cnt)) begin
      errors++;
      $display("[TB] FAIL settle1_counts: got nand=%0d nor=%0d expected %0d",
               err_nand_cnt1, err_nor_cnt1, exp_cnt);
    end
    checks++;
    if (fail_valid1 !== (exp_cnt != 0) || fail_vec1 !== first_set(mask) || pass1 !== (exp_cnt == 0)) begin
      errors++;
      $display("[TB] FAIL settle1_result: got valid=%0d vec=%h pass=%0d expected valid=%0d vec=%h pass=%0d",
               fail_valid1, fail_vec1, pass1, exp_cnt != 0, first_set(mask), exp_cnt == 0);
    end
  endtask

  initial begin
    test_reset();
    test_good_sweep();
    test_fault_models();
    test_abort();
    test_start_ignored_and_reset();
    test_idle_done_boundary();
    test_settle1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
